// File: rtl/estagio_wb_if.sv
// Bus between the EX/MEM stage and the MEM/WB stage (estagio_wb).
// master : EX/MEM side - drives instruction fields, pipeline control and the
//          source addresses being read; receives register-file write port and
//          forwarding data.
// slave  : estagio_wb side.
// Signals:
//   stall, flush, in_valido              pipeline control / validity
//   Saida_ULA, Saida_MemoriaDados, PC,
//   constanteExtendida, sel_WB           write-back candidates and selector
//   in_hab_escrita, in_destino,
//   s_hab_jump                           destination info, link qualifier
//   end_A, end_B                         source addresses read upstream
//   BR_Hab_Escrita, BR_endereco, BR_dado register-file write port
//   fwd_A_hab/dado, fwd_B_hab/dado       forwarding to the operands
interface estagio_wb_if #(
  parameter int LARGURA   = 16,
  parameter int NREG_BITS = 4
);
  logic                 stall;
  logic                 flush;
  logic                 in_valido;
  logic [LARGURA-1:0]   Saida_ULA;
  logic [LARGURA-1:0]   Saida_MemoriaDados;
  logic [LARGURA-1:0]   PC;
  logic [LARGURA-1:0]   constanteExtendida;
  logic [1:0]           sel_WB;
  logic                 in_hab_escrita;
  logic [NREG_BITS-1:0] in_destino;
  logic                 s_hab_jump;
  logic [NREG_BITS-1:0] end_A;
  logic [NREG_BITS-1:0] end_B;

  logic                 BR_Hab_Escrita;
  logic [NREG_BITS-1:0] BR_endereco;
  logic [LARGURA-1:0]   BR_dado;
  logic                 fwd_A_hab;
  logic [LARGURA-1:0]   fwd_A_dado;
  logic                 fwd_B_hab;
  logic [LARGURA-1:0]   fwd_B_dado;

  modport master (
    output stall, flush, in_valido, Saida_ULA, Saida_MemoriaDados, PC,
           constanteExtendida, sel_WB, in_hab_escrita, in_destino,
           s_hab_jump, end_A, end_B,
    input  BR_Hab_Escrita, BR_endereco, BR_dado,
           fwd_A_hab, fwd_A_dado, fwd_B_hab, fwd_B_dado
  );

  modport slave (
    input  stall, flush, in_valido, Saida_ULA, Saida_MemoriaDados, PC,
           constanteExtendida, sel_WB, in_hab_escrita, in_destino,
           s_hab_jump, end_A, end_B,
    output BR_Hab_Escrita, BR_endereco, BR_dado,
           fwd_A_hab, fwd_A_dado, fwd_B_hab, fwd_B_dado
  );
endinterface

// File: rtl/estagio_wb.sv
// MEM/WB pipeline stage.
// Captures the instruction leaving EX/MEM, selects its write-back value at
// capture time, drives the register-file write port and supplies forwarding
// (newest value first) for the two source operands read upstream.
// Ports:
//   clock              rising-edge clock
//   reset              synchronous, active-high
//   wb                 estagio_wb_if.slave (control, fields, BR_*, fwd_*)
// Optional (macro WB_CONTADOR_EN):
//   zera_contador      synchronous clear pulse for the retire counter
//   instr_retiradas    32-bit count of cycles with BR_Hab_Escrita=1
module estagio_wb #(
  parameter int LARGURA   = 16,
  parameter int NREG_BITS = 4
) (
  input  logic          clock,
  input  logic          reset,
  estagio_wb_if.slave   wb
`ifdef WB_CONTADOR_EN
  ,
  input  logic          zera_contador,
  output logic [31:0]   instr_retiradas
`endif
);

  logic                 valido;
  logic                 ja_escrito;
  logic [NREG_BITS-1:0] r_destino;
  logic [LARGURA-1:0]   r_dado;

  logic [LARGURA-1:0]   valor_wb;
  logic                 hab_efetiva;

  // Write-back value of the incoming instruction; link wraps modulo 2^LARGURA.
  always_comb begin
    valor_wb = '0;
    unique case (wb.sel_WB)
      2'b00:   valor_wb = wb.Saida_ULA;
      2'b01:   valor_wb = wb.Saida_MemoriaDados;
      2'b10:   valor_wb = wb.PC + LARGURA'(1);
      default: valor_wb = wb.constanteExtendida;
    endcase
  end

  // Untaken links and register 0 never write.
  assign hab_efetiva = wb.in_valido & wb.in_hab_escrita &
                       (wb.in_destino != '0) &
                       ((wb.sel_WB != 2'b10) | wb.s_hab_jump);

  always_ff @(posedge clock) begin
    if (reset) begin
      valido     <= 1'b0;
      ja_escrito <= 1'b0;
      r_destino  <= '0;
      r_dado     <= '0;
    end else if (wb.flush) begin
      valido     <= 1'b0;
      ja_escrito <= 1'b0;
    end else if (wb.stall) begin
      // Once presented, a held instruction is marked written so it fires once.
      ja_escrito <= valido;
    end else begin
      valido     <= hab_efetiva;
      ja_escrito <= 1'b0;
      r_destino  <= wb.in_destino;
      r_dado     <= valor_wb;
    end
  end

  assign wb.BR_Hab_Escrita = valido & ~ja_escrito;
  assign wb.BR_endereco    = r_destino;
  assign wb.BR_dado        = r_dado;

  // Incoming instruction only forwards when it will actually be captured.
  logic entrada_avanca;
  assign entrada_avanca = hab_efetiva & ~wb.stall & ~wb.flush;

  always_comb begin
    wb.fwd_A_hab  = 1'b0;
    wb.fwd_A_dado = '0;
    if (wb.end_A != '0) begin
      if (entrada_avanca && wb.in_destino == wb.end_A) begin
        wb.fwd_A_hab  = 1'b1;
        wb.fwd_A_dado = valor_wb;
      end else if (valido && r_destino == wb.end_A) begin
        wb.fwd_A_hab  = 1'b1;
        wb.fwd_A_dado = r_dado;
      end
    end
  end

  always_comb begin
    wb.fwd_B_hab  = 1'b0;
    wb.fwd_B_dado = '0;
    if (wb.end_B != '0) begin
      if (entrada_avanca && wb.in_destino == wb.end_B) begin
        wb.fwd_B_hab  = 1'b1;
        wb.fwd_B_dado = valor_wb;
      end else if (valido && r_destino == wb.end_B) begin
        wb.fwd_B_hab  = 1'b1;
        wb.fwd_B_dado = r_dado;
      end
    end
  end

`ifdef WB_CONTADOR_EN
  // Clear wins over a retire in the same cycle.
  always_ff @(posedge clock) begin
    if (reset || zera_contador) begin
      instr_retiradas <= '0;
    end else if (wb.BR_Hab_Escrita) begin
      instr_retiradas <= instr_retiradas + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_estagio_wb.sv
module tb_estagio_wb;

  localparam int LARGURA   = 16;
  localparam int NREG_BITS = 4;

  logic clock;
  logic reset;

  estagio_wb_if #(.LARGURA(LARGURA), .NREG_BITS(NREG_BITS)) bus ();

`ifdef WB_CONTADOR_EN
  logic        zera_contador;
  logic [31:0] instr_retiradas;
  assign zera_contador = 1'b0;
`endif

  estagio_wb #(.LARGURA(LARGURA), .NREG_BITS(NREG_BITS)) dut (
    .clock (clock),
    .reset (reset),
    .wb    (bus)
`ifdef WB_CONTADOR_EN
    ,
    .zera_contador   (zera_contador),
    .instr_retiradas (instr_retiradas)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The stage is one slot: the last captured instruction, whether it is a
  // real write, and how many cycles it has already been presented.
  bit        m_real;
  int        m_presented;
  bit [3:0]  m_dest;
  bit [15:0] m_data;

  function automatic bit [15:0] wb_value();
    case (bus.sel_WB)
      2'd0:    return bus.Saida_ULA;
      2'd1:    return bus.Saida_MemoriaDados;
      2'd2:    return 16'((int'(bus.PC) + 1) % 65536);
      default: return bus.constanteExtendida;
    endcase
  endfunction

  function automatic bit will_write();
    if (!bus.in_valido || !bus.in_hab_escrita) return 1'b0;
    if (bus.in_destino == 0) return 1'b0;
    if (bus.sel_WB == 2'd2 && !bus.s_hab_jump) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit [16:0] fwd_expect(input bit [3:0] src);
    if (src == 0) return 17'd0;
    if (!bus.stall && !bus.flush && will_write() && bus.in_destino == src)
      return {1'b1, wb_value()};
    if (m_real && m_dest == src) return {1'b1, m_data};
    return 17'd0;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_real = 0; m_presented = 0; m_dest = 0; m_data = 0;
    end else if (bus.flush) begin
      m_real = 0; m_presented = 0;
    end else if (bus.stall) begin
      if (m_real) m_presented = m_presented + 1;
    end else begin
      m_real      = will_write();
      m_presented = 0;
      m_dest      = bus.in_destino;
      m_data      = wb_value();
    end
  end

  always @(negedge clock) begin
    if (cmp_on) begin
      bit [16:0] fa, fb;
      fa = fwd_expect(bus.end_A);
      fb = fwd_expect(bus.end_B);
      chk("m_we",    32'(bus.BR_Hab_Escrita), 32'(m_real && m_presented == 0));
      chk("m_addr",  32'(bus.BR_endereco),    32'(m_dest));
      chk("m_data",  32'(bus.BR_dado),        32'(m_data));
      chk("m_fa_h",  32'(bus.fwd_A_hab),      32'(fa[16]));
      chk("m_fa_d",  32'(bus.fwd_A_dado),     32'(fa[15:0]));
      chk("m_fb_h",  32'(bus.fwd_B_hab),      32'(fb[16]));
      chk("m_fb_d",  32'(bus.fwd_B_dado),     32'(fb[15:0]));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic after_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall = 0; bus.flush = 0; bus.in_valido = 0;
    bus.Saida_ULA = 0; bus.Saida_MemoriaDados = 0; bus.PC = 0;
    bus.constanteExtendida = 0; bus.sel_WB = 0; bus.in_hab_escrita = 0;
    bus.in_destino = 0; bus.s_hab_jump = 0;
  endtask

  task automatic put(input bit [1:0] sel, input bit [15:0] val,
                     input bit [3:0] dest, input bit jump);
    bus.in_valido = 1; bus.in_hab_escrita = 1; bus.sel_WB = sel;
    bus.in_destino = dest; bus.s_hab_jump = jump;
    bus.Saida_ULA = 0; bus.Saida_MemoriaDados = 0; bus.PC = 0;
    bus.constanteExtendida = 0;
    case (sel)
      2'd0: bus.Saida_ULA = val;
      2'd1: bus.Saida_MemoriaDados = val;
      2'd2: bus.PC = val;
      default: bus.constanteExtendida = val;
    endcase
  endtask

  initial begin
    idle_inputs();
    bus.end_A = 0; bus.end_B = 0;
    reset = 1;
    after_edge();
    after_edge();
    chk("rst_we",   32'(bus.BR_Hab_Escrita), 32'h0);
    chk("rst_addr", 32'(bus.BR_endereco),    32'h0);
    chk("rst_data", 32'(bus.BR_dado),        32'h0);
    chk("rst_fwdA", 32'(bus.fwd_A_dado),     32'h0);
    reset = 0;
    bus.end_A = 3;
    cmp_on = 1;
    @(negedge clock);
    chk("idle_fwdA_hab", 32'(bus.fwd_A_hab), 32'h0);

    // ALU write-back
    after_edge();
    put(2'd0, 16'h1234, 4'd5, 0);
    after_edge();
    chk("alu_we",   32'(bus.BR_Hab_Escrita), 32'h1);
    chk("alu_addr", 32'(bus.BR_endereco),    32'h5);
    chk("alu_data", 32'(bus.BR_dado),        32'h1234);

    // Taken link with PC wrap, forwarded while incoming
    put(2'd2, 16'hFFFF, 4'd7, 1);
    bus.end_B = 7;
    @(negedge clock);
    chk("link_fwdB_hab",  32'(bus.fwd_B_hab),  32'h1);
    chk("link_fwdB_data", 32'(bus.fwd_B_dado), 32'h0);
    after_edge();
    chk("link_we",   32'(bus.BR_Hab_Escrita), 32'h1);
    chk("link_data", 32'(bus.BR_dado),        32'h0);

    // Untaken link never writes
    put(2'd2, 16'hFFFF, 4'd7, 0);
    after_edge();
    chk("nolink_we", 32'(bus.BR_Hab_Escrita), 32'h0);

    // Constant select
    put(2'd3, 16'h0ABC, 4'd9, 0);
    after_edge();
    chk("const_data", 32'(bus.BR_dado), 32'h0ABC);

    // Load, then stall 3 cycles: a single write, forwarding held throughout
    put(2'd1, 16'hBEEF, 4'd2, 0);
    bus.end_B = 2;
    after_edge();
    chk("ld_we", 32'(bus.BR_Hab_Escrita), 32'h1);
    idle_inputs();
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      after_edge();
      chk("stall_we",       32'(bus.BR_Hab_Escrita), 32'h0);
      chk("stall_fwdB_hab", 32'(bus.fwd_B_hab),      32'h1);
      chk("stall_fwdB_dat", 32'(bus.fwd_B_dado),     32'hBEEF);
    end
    bus.stall = 0;
    after_edge();

    // Forward priority: incoming beats registered unless stalled
    put(2'd0, 16'h0011, 4'd4, 0);
    after_edge();
    put(2'd0, 16'h0022, 4'd4, 0);
    bus.end_A = 4;
    @(negedge clock);
    chk("prio_new", 32'(bus.fwd_A_dado), 32'h0022);
    after_edge();
    bus.stall = 1;
    put(2'd0, 16'h0033, 4'd4, 0);
    @(negedge clock);
    chk("prio_stall", 32'(bus.fwd_A_dado), 32'h0022);
    after_edge();
    idle_inputs();
    after_edge();
    put(2'd0, 16'h0011, 4'd4, 0);
    after_edge();
    put(2'd0, 16'h0022, 4'd4, 0);
    bus.stall = 1;
    @(negedge clock);
    chk("prio_old", 32'(bus.fwd_A_dado), 32'h0011);
    after_edge();
    idle_inputs();
    after_edge();

    // Flush with simultaneous stall discards the incoming write
    put(2'd0, 16'h0055, 4'd3, 0);
    bus.flush = 1; bus.stall = 1;
    after_edge();
    chk("flush_we", 32'(bus.BR_Hab_Escrita), 32'h0);
    bus.flush = 0; bus.stall = 0;

    // Register 0 is never written nor forwarded
    put(2'd0, 16'h7777, 4'd0, 0);
    bus.end_A = 0;
    @(negedge clock);
    chk("r0_fwdA_in", 32'(bus.fwd_A_hab), 32'h0);
    after_edge();
    chk("r0_we",      32'(bus.BR_Hab_Escrita), 32'h0);
    chk("r0_fwdA",    32'(bus.fwd_A_hab),      32'h0);

    // Reset during a stall empties the stage
    put(2'd0, 16'h4321, 4'd6, 0);
    after_edge();
    bus.stall = 1; reset = 1;
    after_edge();
    chk("rst_stall_we",   32'(bus.BR_Hab_Escrita), 32'h0);
    chk("rst_stall_data", 32'(bus.BR_dado),        32'h0);
    reset = 0;
    idle_inputs();
    after_edge();
    after_edge();

    cmp_on = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
